// File: rtl/kfmmc_block_data_io_pkg.sv
// kfmmc_block_data_io_pkg: shared types and constants for the block data sequencer.
package kfmmc_block_data_io_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TIMER_W = 16;

  // Cycles allowed in WAIT_DONE on the start-bit byte before giving up.
  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_ACCEPT = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_ACK         = 3'd4,
    ST_DONE        = 3'd5
  } state_e;

endpackage

// File: rtl/kfmmc_byte_fifo.sv
// kfmmc_byte_fifo: byte FIFO with synchronous flush; head is visible on o_data.
module kfmmc_byte_fifo
  import kfmmc_block_data_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO regardless of push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/kfmmc_block_data_io.sv
// kfmmc_block_data_io: sequences a block of bytes between host FIFOs and the MMC byte engine.
// Optional start-bit timeout enabled by defining KFMMC_BLOCK_DATA_IO_TIMEOUT_EN.
module kfmmc_block_data_io
  import kfmmc_block_data_io_pkg::*;
#(
  parameter int unsigned LENGTH_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    disable_data_io,
  input  logic                    start_block,
  input  logic                    block_direction,
  input  logic [LENGTH_WIDTH-1:0] block_length,
  input  logic                    clear_data_crc,
  input  logic                    check_data_start_bit,
  input  logic                    tx_write,
  input  logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_full,
  input  logic                    rx_read,
  output logic [BYTE_W-1:0]       rx_data,
  output logic                    rx_empty,
  output logic                    block_busy,
  output logic                    block_done,
  output logic                    block_error,
  output logic [LENGTH_WIDTH:0]   remaining_count,
  output logic                    start_communication_to_mmc,
  output logic                    data_io_to_mmc,
  output logic                    check_data_start_bit_to_mmc,
  output logic                    read_continuous_data_to_mmc,
  output logic                    clear_data_crc_to_mmc,
  output logic                    clear_data_interrupt_to_mmc,
  output logic                    mask_data_interrupt_to_mmc,
  output logic                    set_send_data_to_mmc,
  output logic [BYTE_W-1:0]       send_data_to_mmc,
  input  logic [BYTE_W-1:0]       received_data_from_mmc,
  input  logic                    mmc_is_in_connecting,
  input  logic                    sent_data_interrupt_from_mmc,
  input  logic                    received_data_interrupt_from_mmc
);

  localparam int unsigned CNT_W = LENGTH_WIDTH + 1;

  state_e            r_state;
  state_e            w_next_state;
  logic              r_direction;
  logic              r_clear_crc;
  logic              r_check_start;
  logic              r_first_byte;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_block_len;
  logic              w_issue;
  logic              w_tx_pop;
  logic              w_rx_push;
  logic              w_timeout;
  logic              w_timeout_hit;
  logic              w_flush;
  logic              w_start_bit_byte;
  logic              w_tx_empty;
  logic              w_rx_full;
  logic [BYTE_W-1:0] w_tx_head;

  logic              r_start;
  logic              r_set_send;
  logic [BYTE_W-1:0] r_send_data;
  logic              r_data_io;
  logic              r_clear_crc_out;
  logic              r_check_out;
  logic              r_continuous;
  logic              r_clear_int;
  logic              r_done;
  logic              r_busy;
  logic              r_mask;

  // A zero length field encodes the full 2^LENGTH_WIDTH block.
  assign w_block_len      = (block_length == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}}
                                                 : CNT_W'(block_length);
  assign w_start_bit_byte = r_first_byte & r_check_start;
  assign w_flush          = disable_data_io | w_timeout;

  kfmmc_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (tx_write),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (tx_full),
    .o_empty (w_tx_empty)
  );

  kfmmc_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_rx_push),
    .i_data  (received_data_from_mmc),
    .i_pop   (rx_read),
    .o_data  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (rx_empty)
  );

`ifdef KFMMC_BLOCK_DATA_IO_TIMEOUT_EN
  logic [TIMER_W-1:0] r_timer;
  logic               r_error;

  // Count cycles spent waiting for completion of the start-bit byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_timer <= '0;
    end else if ((r_state == ST_WAIT_DONE) && w_start_bit_byte) begin
      r_timer <= r_timer + TIMER_W'(1);
    end else begin
      r_timer <= '0;
    end
  end

  // One-cycle error pulse when the start-bit wait is abandoned.
  always_ff @(posedge clock) begin
    if (!reset) r_error <= 1'b0;
    else        r_error <= w_timeout;
  end

  assign w_timeout_hit = (r_state == ST_WAIT_DONE) && w_start_bit_byte &&
                         (r_timer == TIMEOUT_LIMIT);
  assign block_error   = r_error;
`else
  assign w_timeout_hit = 1'b0;
  assign block_error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and per-cycle FIFO strobes; disable overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_tx_pop     = 1'b0;
    w_rx_push    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_block) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (r_direction ? !w_rx_full : !w_tx_empty) begin
          w_issue      = 1'b1;
          w_tx_pop     = !r_direction;
          w_next_state = ST_WAIT_ACCEPT;
        end
      end
      ST_WAIT_ACCEPT: begin
        if (mmc_is_in_connecting) w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!mmc_is_in_connecting &&
            (r_direction ? received_data_interrupt_from_mmc
                         : sent_data_interrupt_from_mmc)) begin
          w_rx_push    = r_direction;
          w_next_state = ST_ACK;
        end else if (w_timeout_hit) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_next_state = (r_remaining == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (disable_data_io) begin
      w_next_state = ST_IDLE;
      w_issue      = 1'b0;
      w_tx_pop     = 1'b0;
      w_rx_push    = 1'b0;
      w_timeout    = 1'b0;
    end
  end

  // Block context: latched at start, byte count stepped on each acknowledge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_direction   <= 1'b0;
      r_clear_crc   <= 1'b0;
      r_check_start <= 1'b0;
      r_first_byte  <= 1'b0;
      r_remaining   <= '0;
    end else if (w_flush) begin
      r_first_byte  <= 1'b0;
      r_remaining   <= '0;
    end else if ((r_state == ST_IDLE) && start_block) begin
      r_direction   <= block_direction;
      r_clear_crc   <= clear_data_crc;
      r_check_start <= check_data_start_bit;
      r_first_byte  <= 1'b1;
      r_remaining   <= w_block_len;
    end else if (r_state == ST_ACK) begin
      r_first_byte  <= 1'b0;
      r_remaining   <= r_remaining - CNT_W'(1);
    end
  end

  // Registered engine controls and status, derived from the upcoming state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_start         <= 1'b0;
      r_set_send      <= 1'b0;
      r_send_data     <= '0;
      r_data_io       <= 1'b0;
      r_clear_crc_out <= 1'b0;
      r_check_out     <= 1'b0;
      r_continuous    <= 1'b0;
      r_clear_int     <= 1'b0;
      r_done          <= 1'b0;
      r_busy          <= 1'b0;
      r_mask          <= 1'b1;
    end else begin
      r_start         <= w_issue;
      r_set_send      <= w_issue & ~r_direction;
      if (w_issue && !r_direction) r_send_data <= w_tx_head;
      r_data_io       <= w_issue & r_direction;
      r_clear_crc_out <= w_issue & r_first_byte & r_clear_crc;
      r_check_out     <= w_issue & w_start_bit_byte;
      r_continuous    <= w_issue & r_direction & (r_remaining > CNT_W'(1));
      r_clear_int     <= (w_next_state == ST_ACK);
      r_done          <= (w_next_state == ST_DONE);
      r_busy          <= (w_next_state != ST_IDLE);
      r_mask          <= (w_next_state == ST_IDLE);
    end
  end

  assign remaining_count             = r_remaining;
  assign start_communication_to_mmc  = r_start;
  assign set_send_data_to_mmc        = r_set_send;
  assign send_data_to_mmc            = r_send_data;
  assign data_io_to_mmc              = r_data_io;
  assign clear_data_crc_to_mmc       = r_clear_crc_out;
  assign check_data_start_bit_to_mmc = r_check_out;
  assign read_continuous_data_to_mmc = r_continuous;
  assign clear_data_interrupt_to_mmc = r_clear_int;
  assign block_done                  = r_done;
  assign block_busy                  = r_busy;
  assign mask_data_interrupt_to_mmc  = r_mask;

endmodule

// File: doc/kfmmc_block_data_io.md
KFMMC_BLOCK_DATA_IO -- requirements
Module: kfmmc_block_data_io

Interface
REQ-001 SHALL have parameter LENGTH_WIDTH, default 9: width of the block byte count; block_length=0 means 2^LENGTH_WIDTH bytes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entries per byte FIFO, power of 2, minimum 2.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports are named clock and reset.
REQ-004 Ports, as name, direction, width and meaning:
  - clock  in  1  rising-edge clock
  - reset  in  1  synchronous active-low reset
  - disable_data_io  in  1  abort and flush
  - start_block  in  1  start a block transfer, sampled in IDLE
  - block_direction  in  1  1=receive, 0=send
  - block_length  in  LENGTH_WIDTH  byte count
  - clear_data_crc  in  1  clear CRC before the first byte
  - check_data_start_bit  in  1  wait for the start bit before the first received byte
  - tx_write  in  1  push tx_data
  - tx_data  in  8  byte to send
  - tx_full  out  1  tx FIFO full
  - rx_read  in  1  pop rx_data
  - rx_data  out  8  rx FIFO head
  - rx_empty  out  1  rx FIFO empty
  - block_busy  out  1  transfer active
  - block_done  out  1  one-cycle completion pulse
  - block_error  out  1  one-cycle start-bit timeout pulse
  - remaining_count  out  LENGTH_WIDTH+1  bytes left in the block
  - start_communication_to_mmc  out  1  byte engine kick
  - data_io_to_mmc  out  1  direction to the engine
  - check_data_start_bit_to_mmc  out  1  start-bit check for this byte
  - read_continuous_data_to_mmc  out  1  more bytes follow
  - clear_data_crc_to_mmc  out  1  CRC clear for this byte
  - clear_data_interrupt_to_mmc  out  1  acknowledge the engine interrupt
  - mask_data_interrupt_to_mmc  out  1  mask engine interrupts
  - set_send_data_to_mmc  out  1  load send_data_to_mmc
  - send_data_to_mmc  out  8  byte to the engine
  - received_data_from_mmc  in  8  byte from the engine
  - mmc_is_in_connecting  in  1  engine busy
  - sent_data_interrupt_from_mmc  in  1  send byte complete
  - received_data_interrupt_from_mmc  in  1  receive byte complete

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, ACK and DONE.
REQ-006 IDLE: on start_block=1, SHALL latch direction, the length (0 maps to 2^LENGTH_WIDTH) and both first-byte flags; block_busy=1 from the next cycle.
REQ-007 ISSUE, send: SHALL stall while the tx FIFO is empty; otherwise, for one cycle, drive set_send_data_to_mmc=1 with send_data_to_mmc=FIFO head, pop it, and pulse start_communication_to_mmc.
REQ-008 ISSUE, receive: SHALL stall while the rx FIFO is full; otherwise pulse start_communication_to_mmc for one cycle.
REQ-009 During the start pulse: data_io_to_mmc=direction; clear_data_crc_to_mmc and check_data_start_bit_to_mmc=1 only on byte 1 when latched; read_continuous_data_to_mmc=1 when receiving and remaining_count>1.
REQ-010 WAIT_ACCEPT SHALL hold until mmc_is_in_connecting=1, then move to WAIT_DONE.
REQ-011 WAIT_DONE SHALL hold until mmc_is_in_connecting=0 and the interrupt matching the direction is 1; a receive then pushes received_data_from_mmc into the rx FIFO.
REQ-012 ACK SHALL pulse clear_data_interrupt_to_mmc for one cycle and decrement remaining_count; at 0 go to DONE, otherwise ISSUE.
REQ-013 DONE SHALL pulse block_done for one cycle, then go to IDLE.
REQ-014 mask_data_interrupt_to_mmc SHALL be 1 exactly when in IDLE.
REQ-015 FIFO write when full and read when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH; a simultaneous push and pop keeps the count unchanged.
REQ-016 disable_data_io=1 SHALL force IDLE next cycle and flush both FIFOs with all pulses low; disable wins over a simultaneous start_block.
REQ-017 start_block outside IDLE SHALL be ignored.

Reset
REQ-018 reset=0 at a clock edge SHALL give: state IDLE; both FIFOs empty (tx_full=0, rx_empty=1); rx_data=0; remaining_count=0; all other outputs 0 except mask_data_interrupt_to_mmc=1. This applies mid-transfer too.

Configuration
REQ-019 With KFMMC_BLOCK_DATA_IO_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_DONE on the start-bit byte; reaching 0xFFFF pulses block_error, flushes the FIFOs and returns to IDLE without block_done.
REQ-020 Without the macro: no counter; the block waits indefinitely and block_error is tied to 0.

Structure
REQ-021 Package kfmmc_block_data_io_pkg SHALL hold the FSM state enum and the timeout limit constant.
REQ-022 Sub-module kfmmc_byte_fifo (8-bit, parameter FIFO_DEPTH, synchronous flush) SHALL be instantiated twice, for tx and rx.

Verification
REQ-023 Send: push 0xAB,0xCD, start length=2 direction=0 clear_data_crc=1 -> send_data_to_mmc 0xAB then 0xCD; clear_data_crc_to_mmc on byte 1 only; block_done after the second ACK.
REQ-024 Receive: length=3 check_data_start_bit=1, engine returns 0x11,0x22,0x33 -> rx pops 0x11,0x22,0x33; read_continuous high on bytes 1-2, low on 3.
REQ-025 Stall: send length=2 with one byte queued -> stays in ISSUE until a second tx_write, no start pulse meanwhile.
REQ-026 Abort: disable_data_io=1 in WAIT_DONE of byte 2 -> IDLE next cycle, rx_empty=1, block_done never pulses.
REQ-027 Length 0 with LENGTH_WIDTH=2 -> exactly 4 byte transactions; remaining_count goes 4,3,2,1,0.
REQ-028 With the macro: start-bit byte whose interrupt never arrives -> block_error after 0xFFFF cycles, then IDLE.
